// File: rtl/tree_adder_sequencer_if.sv
// Result handoff bus between the tree adder sequencer and its consumer.
// The master offers result/res_valid and the slave answers with res_ready.
interface tree_adder_sequencer_if #(
  parameter int ADDER_DATASIZE = 16
);
  logic [ADDER_DATASIZE-1:0] result;
  logic                      res_valid;
  logic                      res_ready;

  modport master (
    output result,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  result,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/tree_adder_sequencer.sv
// Drives the tree adder array command bus: load, sum-decimate passes, capture
// of the top-left sum, then offers the frame total over a valid/ready handoff.
module tree_adder_sequencer #(
  parameter int ADDER_DATASIZE         = 16,
  parameter int CMD_WIDTH              = 4,
  parameter int GRID_LOG2              = 3,
  parameter int CMD_IDLE               = 0,
  parameter int CMD_TOPLOAD_SHADOW_A   = 9,
  parameter int CMD_TOPLOAD_SHADOW_B   = 10,
  parameter int CMD_SUMDECIMATE        = 11,
  parameter int CMD_TOPLOAD_MULTIPLIER = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                src_sel,
  output logic [CMD_WIDTH-1:0]      cmd_out,
  input  logic [ADDER_DATASIZE-1:0] sum00_in,
  output logic                      busy,
  output logic                      err,
  tree_adder_sequencer_if.master    res_if
);

  localparam int CNT_W = (GRID_LOG2 > 1) ? $clog2(GRID_LOG2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((GRID_LOG2 > 1) ? GRID_LOG2 - 2 : 0);

  localparam logic [CMD_WIDTH-1:0] C_IDLE  = CMD_WIDTH'(CMD_IDLE);
  localparam logic [CMD_WIDTH-1:0] C_LD_A  = CMD_WIDTH'(CMD_TOPLOAD_SHADOW_A);
  localparam logic [CMD_WIDTH-1:0] C_LD_B  = CMD_WIDTH'(CMD_TOPLOAD_SHADOW_B);
  localparam logic [CMD_WIDTH-1:0] C_DECIM = CMD_WIDTH'(CMD_SUMDECIMATE);
  localparam logic [CMD_WIDTH-1:0] C_LD_M  = CMD_WIDTH'(CMD_TOPLOAD_MULTIPLIER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DECIM,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CMD_WIDTH-1:0]        cmd_q, cmd_d;
  logic                        busy_q, busy_d;
  logic                        err_q, err_d;
  logic [ADDER_DATASIZE-1:0]   result_q, result_d;
  logic                        valid_q, valid_d;

  function automatic logic [CMD_WIDTH-1:0] load_code(input logic [1:0] sel);
    case (sel)
      2'd1:    load_code = C_LD_A;
      2'd2:    load_code = C_LD_B;
      default: load_code = C_LD_M;
    endcase
  endfunction

  // The command register is computed from the next state, so the load code
  // registered on the accepting edge is the only copy of src_sel that is kept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = C_IDLE;
    err_d    = 1'b0;
    result_d = result_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (src_sel == 2'd3) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            cmd_d   = load_code(src_sel);
          end
        end
      end
      S_LOAD: begin
        if (GRID_LOG2 > 1) begin
          state_d = S_DECIM;
          cnt_d   = '0;
          cmd_d   = C_DECIM;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_DECIM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          cmd_d = C_DECIM;
        end
      end
      S_CAPTURE: begin
        result_d = sum00_in;
        valid_d  = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (res_if.res_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cmd_q    <= C_IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign cmd_out          = cmd_q;
  assign busy             = busy_q;
  assign err              = err_q;
  assign res_if.result    = result_q;
  assign res_if.res_valid = valid_q;

endmodule

// File: doc/tree_adder_sequencer.md
# tree_adder_sequencer

Controller that drives the shared `cmdinput` bus of the single-level tree adder pixel array. It loads the pixel registers from a selected source (multiplier, shadow A, or shadow B), then issues the sum-decimate passes that collapse the grid into the top-left element. It captures that element's `sumout` as the frame total and hands it off over a valid/ready handshake. It sits between the frame-level control logic and the tree adder array.

## Interface

Parameters:
- `ADDER_DATASIZE`, default 16: width of pixel values, sums and `result`.
- `CMD_WIDTH`, default 4: width of the array command bus.
- `GRID_LOG2`, default 3: the grid is 2^GRID_LOG2 x 2^GRID_LOG2 pixels. Legal range is 1..7.
- `CMD_IDLE`, default 0: hold code. The array keeps its register contents.
- `CMD_TOPLOAD_SHADOW_A`, default 9: load code for shadow A.
- `CMD_TOPLOAD_SHADOW_B`, default 10: load code for shadow B.
- `CMD_SUMDECIMATE`, default 11: decimate code.
- `CMD_TOPLOAD_MULTIPLIER`, default 12: load code for the multiplier.

Ports:
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request a frame sum. Sampled only in IDLE.
- `src_sel` input, 2 bits: load source. 0 = multiplier, 1 = shadow A, 2 = shadow B, 3 = illegal.
- `cmd_out` output, CMD_WIDTH bits: registered command, wired to every element's `cmdinput`.
- `sum00_in` input, ADDER_DATASIZE bits: `sumout` of the top-left element.
- `busy` output, 1 bit: high in every state except IDLE.
- `err` output, 1 bit: one-cycle pulse when `start` is sampled with `src_sel`=3.
- `result` output, ADDER_DATASIZE bits: captured frame total.
- `res_valid` output, 1 bit: `result` is valid and is being offered.
- `res_ready` input, 1 bit: consumer accepts `result`.

## Operation

- States are IDLE, LOAD, DECIM, CAPTURE and OUT. A pass counter of ceil(log2(GRID_LOG2)) bits, minimum 1, counts decimate cycles.
- IDLE:
  - `cmd_out`=CMD_IDLE.
  - If `start` is high and `src_sel`!=3: latch `src_sel` and go to LOAD.
  - If `start` is high and `src_sel`=3: pulse `err` for one cycle and stay in IDLE.
- LOAD, one cycle:
  - `cmd_out` is the load code for the latched source (12, 9 or 10).
  - Next state is DECIM with the counter cleared if GRID_LOG2>1. Otherwise it is CAPTURE.
- DECIM, exactly GRID_LOG2-1 cycles:
  - `cmd_out`=CMD_SUMDECIMATE. The counter increments each cycle.
  - Leave for CAPTURE when counter==GRID_LOG2-2.
- CAPTURE, one cycle:
  - `cmd_out`=CMD_IDLE.
  - At the end of the cycle, `result` <= `sum00_in` and the state goes to OUT.
- OUT:
  - `cmd_out`=CMD_IDLE and `res_valid`=1. `result` is held stable.
  - When `res_ready`=1, the transfer completes and the state goes to IDLE with `res_valid` dropping the next cycle.
- `start`, including a `start` with `src_sel`=3, is ignored in every state other than IDLE. No `err` pulse is generated outside IDLE.
- `src_sel` is sampled only on the accepting edge. Later changes do not affect the frame in flight.
- Arithmetic is performed entirely in the array, modulo 2^ADDER_DATASIZE. The block does not saturate and does not widen.
- The array contents after a frame are undefined. Every frame reloads the array in LOAD.

## Timing

- Reset values: state=IDLE, `cmd_out`=CMD_IDLE, `busy`=0, `err`=0, `result`=0, `res_valid`=0, counter=0.
- Reset is applied on any edge where `rst`=1, including mid-frame and in OUT. A pending result is discarded. `cmd_out` returns to CMD_IDLE on that same edge.
- `cmd_out`, `busy`, `err` and `res_valid` are all registered, so there are no combinational paths from inputs to outputs.
- Let the start-accepting edge be E0:
  - `cmd_out`=load code during the cycle after E0.
  - The array loads at E1.
  - Decimates are applied at E2 through E_G, where G=GRID_LOG2.
  - `result` is captured and `res_valid` rises at E_{G+1}.
  - Latency from `start` to `res_valid` is GRID_LOG2+1 cycles. For the default, that is 4 cycles.
- `busy` rises at E0. It falls on the edge after the `res_valid` && `res_ready` cycle.
- Back-to-back throughput: the earliest next `start` is accepted on the edge after `busy` falls. A frame therefore takes a minimum of GRID_LOG2+3 cycles, when `res_ready` is tied high.

## Test plan

- **Default frame from the multiplier.** Use GRID_LOG2=3 and a behavioural 8x8 array model with every pixel=1. Assert `start` with `src_sel`=0. Required: `cmd_out` sequence is 12, 11, 11, 0; `res_valid` rises 4 cycles after the accepting edge; `result`=64.
- **Shadow sources and wrap-around.** Set shadow A pixels to 0x0400 and shadow B pixels to value i (0..63), and run one frame with each source. Required: load code 9 then 10; results are 0x0000 (64x0x0400 wraps mod 2^16) and 2016.
- **Illegal source and busy.**
  - `start` with `src_sel`=3 in IDLE: `err` pulses for one cycle, `busy` stays 0, `cmd_out` stays 0.
  - `start` pulsed during DECIM: no effect on the sequence or `result`.
- **Output backpressure.** Hold `res_ready`=0 for 5 cycles in OUT while changing `sum00_in`. Required: `result` and `res_valid` are stable and `cmd_out`=0. Then raise `res_ready`: `res_valid` drops next cycle and `busy` drops the same cycle.
- **Reset mid-frame and in OUT.** Assert `rst` during DECIM, and separately in OUT. Required on the next cycle: `cmd_out`=0, `busy`=0, `res_valid`=0, `result`=0. A new `start` then completes normally.
- **GRID_LOG2=1 (2x2 grid).** Pixels are 1, 2, 3, 4. Required: `cmd_out` is 12 then 0 with no decimate cycles; `result`=10 two cycles after the accepting edge.
